max_count_collector: RTL and testbench
======================================

# max_count_collector

Histogram collector feeding the APB register block: when software sets the start bit (StartColl), it counts occurrences of each sample value over a fixed window. It then scans the bins and presents the most frequent value and its count on MaxCountData/MaxCount, which the register block reads back. One instance per channel; the top level instantiates three, driving MaxCountData1..3/MaxCount1..3.

## Interface
- DATA_ZISE, 4: sample width; bin count = 2^DATA_ZISE.
- LENGTH_ADD, 5: bin counter width; also the width of MaxCount.
- WINDOW, 31: number of valid samples per collection; range 1..65535.

- FCLK_CLK1  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- StartColl  in  1  level from the register block; a rising edge starts a collection; low aborts it.
- DataIn  in  DATA_ZISE  sample value.
- DataValid  in  1  DataIn is valid this cycle.
- CollBusy  out  1  high in CLEAR, COLLECT and SCAN.
- CollDone  out  1  one-cycle pulse when new results are loaded.
- MaxCountData  out  DATA_ZISE  most frequent value of the last completed collection.
- MaxCount  out  LENGTH_ADD  occurrence count of MaxCountData.

## Operation
- State machine: IDLE, CLEAR, COLLECT, SCAN, DONE.
- start_d register holds StartColl delayed by one cycle. rise = StartColl & ~start_d.
- IDLE -> CLEAR on rise.
- CLEAR (1 cycle): all bins and the sample counter are zeroed. Then go to COLLECT.
- COLLECT: each cycle with DataValid=1, bin[DataIn] increments. A bin saturates at 2^LENGTH_ADD-1 and does not wrap. The sample counter also increments. DataValid=0 cycles are ignored.
- When the WINDOW-th valid sample is accepted, go to SCAN on the next cycle.
- SCAN: walks index 0..2^DATA_ZISE-1, one bin per cycle.
  - Keeps best_val/best_cnt, both initialised to 0/0.
  - Replaces them only when bin > best_cnt (strictly greater), so ties resolve to the lowest value.
  - An all-zero histogram is impossible because WINDOW>=1.
- End of SCAN: MaxCountData/MaxCount load best_val/best_cnt, CollDone pulses, and the state moves to DONE.
- DONE -> IDLE when StartColl=0. A new run therefore needs StartColl low and then high again.
- Abort: StartColl=0 in CLEAR, COLLECT or SCAN sends the state to IDLE the next cycle. MaxCountData/MaxCount keep their previous values and there is no CollDone.
- A rise in any state other than IDLE is ignored.
- Sample counter width: clog2(WINDOW+1).
- SCAN index width: DATA_ZISE+1, so it can detect the terminal count.

## Timing
- Reset values: state IDLE, start_d 0, CollBusy 0, CollDone 0, MaxCountData 0, MaxCount 0, all bins 0.
- Reset mid-operation returns everything to the reset values within one cycle. Earlier results are lost.
- StartColl sampled high at edge N (low at N-1): CLEAR during N..N+1, COLLECT from edge N+1. The first sample can be accepted at edge N+2.
- A sample accepted at edge K is visible in its bin after edge K.
- Last sample accepted at edge L: SCAN occupies 2^DATA_ZISE cycles. Results and CollDone are registered at edge L+1+2^DATA_ZISE.
- CollBusy is registered from the state and is high exactly while the state is CLEAR, COLLECT or SCAN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package, max_count_pkg:
  - state enum (IDLE/CLEAR/COLLECT/SCAN/DONE);
  - default DATA_ZISE/LENGTH_ADD/WINDOW constants, shared with the register block's read mux width rules.
- Sub-module count_bank:
  - 2^DATA_ZISE x LENGTH_ADD register array with synchronous clear, a saturating increment port (en, idx), and an asynchronous read port (ridx) for SCAN;
  - uses the same FCLK_CLK1 and rst.
- FSM, sample counter and scan comparator live in max_count_collector.

## Test plan
- Defaults, 31 samples all value 5 with DataValid held high -> after SCAN, MaxCountData=5, MaxCount=31, one CollDone pulse at L+17, CollBusy low afterwards.
- 10x value 3, 10x value 9, 11x distinct other values -> MaxCountData=3, MaxCount=10 (lowest-value tie-break).
- DataValid toggling 1/0 every cycle with value 7 -> collection ends exactly after 31 valid samples, with MaxCount=31. Invalid-cycle DataIn=2 is never counted.
- WINDOW=40, all samples value 2 -> MaxCount saturates at 31, MaxCountData=2.
- Finish a run (value 5), then start a second run and drop StartColl after 10 samples -> state returns to IDLE, outputs stay 5/31, no CollDone. Holding StartColl high after DONE does not start a new run.
- Assert rst during SCAN -> all outputs 0 next cycle. A fresh StartColl rise then gives correct results.

Source files
------------

// File: rtl/max_count_collector_pkg.sv
// Shared definitions for the histogram max-count collectors and their register block.
package max_count_pkg;

  localparam int DEF_DATA_ZISE  = 4;
  localparam int DEF_LENGTH_ADD = 5;
  localparam int DEF_WINDOW     = 31;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    SCAN,
    DONE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == CLEAR) || (s == COLLECT) || (s == SCAN);
  endfunction

endpackage

// File: rtl/max_count_collector_if.sv
// Control/result bundle between the register block (master) and one collector (slave).
interface max_count_collector_if #(
  parameter int DATA_ZISE  = max_count_pkg::DEF_DATA_ZISE,
  parameter int LENGTH_ADD = max_count_pkg::DEF_LENGTH_ADD
);
  logic                  StartColl;
  logic [DATA_ZISE-1:0]  DataIn;
  logic                  DataValid;
  logic                  CollBusy;
  logic                  CollDone;
  logic [DATA_ZISE-1:0]  MaxCountData;
  logic [LENGTH_ADD-1:0] MaxCount;

  modport master (
    output StartColl, DataIn, DataValid,
    input  CollBusy, CollDone, MaxCountData, MaxCount
  );

  modport slave (
    input  StartColl, DataIn, DataValid,
    output CollBusy, CollDone, MaxCountData, MaxCount
  );
endinterface

// File: rtl/max_count_collector_count_bank.sv
// Bin array: synchronous clear, saturating increment on one index, async read on another.
module count_bank #(
  parameter int DATA_ZISE  = 4,
  parameter int LENGTH_ADD = 5
) (
  input  logic                  FCLK_CLK1,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_ZISE-1:0]  idx,
  input  logic [DATA_ZISE-1:0]  ridx,
  output logic [LENGTH_ADD-1:0] rdata
);
  localparam int unsigned NBINS = 2 ** DATA_ZISE;

  logic [LENGTH_ADD-1:0] bin_q [NBINS];

  always_ff @(posedge FCLK_CLK1) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < NBINS; i++) begin
        bin_q[i] <= '0;
      end
    end else if (en && (bin_q[idx] != '1)) begin
      bin_q[idx] <= bin_q[idx] + LENGTH_ADD'(1);
    end
  end

  assign rdata = bin_q[ridx];

endmodule

// File: rtl/max_count_collector.sv
// Histogram collector: counts sample values over a window, then scans for the most frequent one.
module max_count_collector
  import max_count_pkg::*;
#(
  parameter int DATA_ZISE  = DEF_DATA_ZISE,
  parameter int LENGTH_ADD = DEF_LENGTH_ADD,
  parameter int WINDOW     = DEF_WINDOW
) (
  input logic FCLK_CLK1,
  input logic rst,
  max_count_collector_if.slave bus
);
  localparam int NBINS = 2 ** DATA_ZISE;
  localparam int CW    = $clog2(WINDOW + 1);
  localparam int IW    = DATA_ZISE + 1;

  state_e                state_q, state_d;
  logic                  start_q;
  logic                  rise;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_ZISE-1:0]  best_val_q;
  logic [LENGTH_ADD-1:0] best_cnt_q;
  logic                  busy_q, busy_d;
  logic                  done_q, load_d;
  logic [DATA_ZISE-1:0]  mdata_q;
  logic [LENGTH_ADD-1:0] mcnt_q;
  logic                  accept, last, scan_end;
  logic [LENGTH_ADD-1:0] rdata;

  assign rise     = bus.StartColl & ~start_q;
  assign accept   = (state_q == COLLECT) && bus.DataValid;
  assign last     = accept && (cnt_q == CW'(WINDOW - 1));
  assign scan_end = (idx_q == IW'(NBINS));

  count_bank #(
    .DATA_ZISE (DATA_ZISE),
    .LENGTH_ADD(LENGTH_ADD)
  ) u_bank (
    .FCLK_CLK1(FCLK_CLK1),
    .rst      (rst),
    .clr      (state_q == CLEAR),
    .en       (accept),
    .idx      (bus.DataIn),
    .ridx     (idx_q[DATA_ZISE-1:0]),
    .rdata    (rdata)
  );

  always_ff @(posedge FCLK_CLK1) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.StartColl;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = CLEAR;
      CLEAR:   state_d = bus.StartColl ? COLLECT : IDLE;
      COLLECT: if (!bus.StartColl) state_d = IDLE;
               else if (last)      state_d = SCAN;
      SCAN:    if (!bus.StartColl) state_d = IDLE;
               else if (scan_end)  state_d = DONE;
      DONE:    if (!bus.StartColl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results load only on a completed scan; an abort leaves previous results untouched.
  always_comb begin
    busy_d = is_busy(state_d);
    load_d = (state_q == SCAN) && bus.StartColl && scan_end;
  end

  always_ff @(posedge FCLK_CLK1) begin
    if (rst || (state_q == CLEAR)) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Strict compare keeps the earliest (lowest-valued) bin on ties.
  always_ff @(posedge FCLK_CLK1) begin
    if (rst || (state_q != SCAN)) begin
      idx_q <= '0;
    end else if (!scan_end) begin
      idx_q <= idx_q + IW'(1);
    end
    if (rst || (state_q == CLEAR)) begin
      best_val_q <= '0;
      best_cnt_q <= '0;
    end else if ((state_q == SCAN) && !scan_end && (rdata > best_cnt_q)) begin
      best_val_q <= idx_q[DATA_ZISE-1:0];
      best_cnt_q <= rdata;
    end
  end

  always_ff @(posedge FCLK_CLK1) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mdata_q <= '0;
      mcnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= load_d;
      if (load_d) begin
        mdata_q <= best_val_q;
        mcnt_q  <= best_cnt_q;
      end
    end
  end

  assign bus.CollBusy     = busy_q;
  assign bus.CollDone     = done_q;
  assign bus.MaxCountData = mdata_q;
  assign bus.MaxCount     = mcnt_q;

endmodule

// File: tb/tb_max_count_collector.sv
// Directed bench for max_count_collector: table of collection runs plus abort/reset sequences.
module tb_max_count_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_count_collector_if #(.DATA_ZISE(4), .LENGTH_ADD(5)) if0 ();
  max_count_collector_if #(.DATA_ZISE(4), .LENGTH_ADD(5)) if1 ();

  max_count_collector #(.DATA_ZISE(4), .LENGTH_ADD(5), .WINDOW(31)) dut (
    .FCLK_CLK1(clk),
    .rst      (rst),
    .bus      (if0)
  );

  max_count_collector #(.DATA_ZISE(4), .LENGTH_ADD(5), .WINDOW(40)) dut40 (
    .FCLK_CLK1(clk),
    .rst      (rst),
    .bus      (if1)
  );

  typedef struct {
    int unsigned use40;
    int unsigned toggle;
    int unsigned va;
    int unsigned na;
    int unsigned vb;
    int unsigned nb;
    logic [15:0] fill;
    int unsigned exp_val;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs [5];
  int   n_chk  = 0;
  int   n_fail = 0;
  int unsigned sel = 0;

  logic       o_busy, o_done;
  logic [3:0] o_data;
  logic [4:0] o_cnt;

  always_comb begin
    o_busy = (sel != 0) ? if1.CollBusy     : if0.CollBusy;
    o_done = (sel != 0) ? if1.CollDone     : if0.CollDone;
    o_data = (sel != 0) ? if1.MaxCountData : if0.MaxCountData;
    o_cnt  = (sel != 0) ? if1.MaxCount     : if0.MaxCount;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_start(input logic b);
    if (sel != 0) if1.StartColl = b;
    else          if0.StartColl = b;
  endtask

  task automatic set_data(input int unsigned d, input logic v);
    if0.DataIn    = 4'(d);
    if1.DataIn    = 4'(d);
    if0.DataValid = v;
    if1.DataValid = v;
  endtask

  task automatic run(input vec_t v, input int id, input bit keep);
    int unsigned q [$];
    int since, pulses, first;
    sel = v.use40;
    set_start(1'b0);
    set_data(0, 1'b0);
    tick();
    tick();
    set_start(1'b1);
    tick();
    chk($sformatf("v%0d busy_in_clear", id), o_busy, 1);
    tick();
    for (int unsigned i = 0; i < v.na; i++) q.push_back(v.va);
    for (int unsigned i = 0; i < v.nb; i++) q.push_back(v.vb);
    for (int unsigned b = 0; b < 16; b++) if (v.fill[b]) q.push_back(b);
    since = 0;
    foreach (q[i]) begin
      set_data(q[i], 1'b1);
      tick();
      since = 0;
      if (v.toggle != 0) begin
        set_data(2, 1'b0);
        tick();
        since = 1;
      end
    end
    set_data(0, 1'b0);
    pulses = 0;
    first  = 0;
    for (int k = since + 1; k <= 20; k++) begin
      tick();
      if (o_done) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 2) chk($sformatf("v%0d busy_in_scan", id), o_busy, 1);
    end
    chk($sformatf("v%0d done_cycle", id), first, 17);
    chk($sformatf("v%0d done_pulses", id), pulses, 1);
    chk($sformatf("v%0d max_data", id), o_data, v.exp_val);
    chk($sformatf("v%0d max_count", id), o_cnt, v.exp_cnt);
    chk($sformatf("v%0d busy_after", id), o_busy, 0);
    if (!keep) begin
      set_start(1'b0);
      tick();
      tick();
    end
  endtask

  initial begin
    vec_t v;
    int pulses;
    int busy_seen;

    vecs[0] = '{use40:0, toggle:0, va:5,  na:31, vb:0, nb:0,  fill:16'h0000, exp_val:5,  exp_cnt:31};
    vecs[1] = '{use40:0, toggle:0, va:9,  na:10, vb:3, nb:10, fill:16'h1DF7, exp_val:3,  exp_cnt:10};
    vecs[2] = '{use40:0, toggle:1, va:7,  na:31, vb:0, nb:0,  fill:16'h0000, exp_val:7,  exp_cnt:31};
    vecs[3] = '{use40:1, toggle:0, va:2,  na:40, vb:0, nb:0,  fill:16'h0000, exp_val:2,  exp_cnt:31};
    vecs[4] = '{use40:0, toggle:0, va:15, na:20, vb:0, nb:11, fill:16'h0000, exp_val:15, exp_cnt:20};

    rst = 1'b1;
    if0.StartColl = 1'b0;
    if1.StartColl = 1'b0;
    set_data(0, 1'b0);
    tick();
    tick();
    chk("reset busy", if0.CollBusy, 0);
    chk("reset done", if0.CollDone, 0);
    chk("reset data", if0.MaxCountData, 0);
    chk("reset count", if0.MaxCount, 0);
    chk("reset count w40", if1.MaxCount, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run(vecs[i], i, 1'b0);

    // Completed run, then StartColl held high must not restart, then an aborted run.
    v = '{use40:0, toggle:0, va:5, na:31, vb:0, nb:0, fill:16'h0000, exp_val:5, exp_cnt:31};
    run(v, 10, 1'b1);
    pulses = 0;
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_done) pulses++;
      if (o_busy) busy_seen++;
    end
    chk("hold_high busy", busy_seen, 0);
    chk("hold_high done", pulses, 0);
    set_start(1'b0);
    tick();
    set_start(1'b1);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      set_data(1, 1'b1);
      tick();
    end
    set_data(0, 1'b0);
    set_start(1'b0);
    tick();
    tick();
    chk("abort busy", o_busy, 0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_done) pulses++;
    end
    chk("abort done", pulses, 0);
    chk("abort data", o_data, 5);
    chk("abort count", o_cnt, 31);

    // Reset in the middle of SCAN, then a fresh run.
    sel = 0;
    set_start(1'b1);
    tick();
    tick();
    for (int k = 0; k < 31; k++) begin
      set_data(4, 1'b1);
      tick();
    end
    set_data(0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst busy", o_busy, 1);
    rst = 1'b1;
    set_start(1'b0);
    tick();
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst data", o_data, 0);
    chk("rst count", o_cnt, 0);
    rst = 1'b0;
    tick();
    v = '{use40:0, toggle:0, va:6, na:31, vb:0, nb:0, fill:16'h0000, exp_val:6, exp_cnt:31};
    run(v, 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
